port_bus_arbiter: RTL and testbench

Shares one 32-bit bidirectional fabric port (the `port_data` conduit exported by `soc_system`) between two requesters, for example an HPS-bridge master and a fabric DMA. Sequences each transfer as a drive phase or a sample phase, and always inserts a guaranteed turnaround cycle. Sits in the top level beside `soc_system`. The top level owns the tri-state buffer; this block only produces output-enable, output data and the sampled input.

---
 rtl/port_arb_pkg.sv | 21 ++
 rtl/port_arb_rr.sv | 41 ++++
 rtl/port_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_port_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_arb_pkg.sv
//==============================================================================
// Module      : port_arb_pkg
// Description : Shared types and constants for the port bus arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package port_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2,
        WAIT  = 2'd3
    } port_arb_state_t;

endpackage : port_arb_pkg

`default_nettype wire

// File: rtl/port_arb_rr.sv
//==============================================================================
// Module      : port_arb_rr
// Description : Combinational one-hot grant for two requesters. Round-robin by
//               default; PORT_ARB_FIXED_PRIO_EN selects fixed priority (req 0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module port_arb_rr
    import port_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_owner,
    output logic [NUM_REQ-1:0] grant
);

`ifdef PORT_ARB_FIXED_PRIO_EN
    logic w_unused_last_owner;
    assign w_unused_last_owner = last_owner;

    always_comb begin
        grant = '0;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    // Under contention the requester that did not own the last transfer wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_owner ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule : port_arb_rr

`default_nettype wire

// File: rtl/port_bus_arbiter.sv
//==============================================================================
// Module      : port_bus_arbiter
// Description : Shares one bidirectional port between two requesters with a
//               guaranteed turnaround cycle. Option: PORT_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module port_bus_arbiter
    import port_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int WR_HOLD = 2,
    parameter int RD_WAIT = 2
)
(
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] req_write,
    input  logic [DW-1:0]      req_wdata0,
    input  logic [DW-1:0]      req_wdata1,
    output logic [NUM_REQ-1:0] done,
    output logic [DW-1:0]      rdata,
    output logic               port_oe,
    output logic [DW-1:0]      port_dout,
    input  logic [DW-1:0]      port_din
);

    localparam int c_MAX_CNT = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    port_arb_state_t     r_state;
    port_arb_state_t     w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic [NUM_REQ-1:0]  r_done;
    logic                w_accept;
    logic                w_acc_idx;
    logic                w_acc_write;
    logic                w_last_owner;
    logic                w_sample;
    logic                r_owner;
    logic                r_write;
    logic [DW-1:0]       r_dout;
    logic [DW-1:0]       r_rdata;

    port_arb_rr u_rr (
        .valid      (req_valid),
        .last_owner (w_last_owner),
        .grant      (w_grant)
    );

    assign w_accept    = (r_state == IDLE) && (|w_grant);
    assign w_acc_idx   = w_grant[1];
    assign w_acc_write = |(w_grant & req_write);
    assign w_sample    = (r_state == WAIT) && (r_cnt == '0);

    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    // Decoded from state so the enable drops the instant reset asserts.
    assign port_oe   = (r_state == DRIVE);
    assign port_dout = r_dout;
    assign done      = r_done;
    assign rdata     = r_rdata;

`ifdef PORT_ARB_FIXED_PRIO_EN
    assign w_last_owner = 1'b1;
`else
    // Resetting to 1 makes requester 0 the preferred winner after reset.
    logic r_last_owner;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_last_owner <= 1'b1;
        end else if (w_accept) begin
            r_last_owner <= w_acc_idx;
        end
    end

    assign w_last_owner = r_last_owner;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_acc_write) begin
                        w_state_nxt = DRIVE;
                        w_cnt_nxt   = c_WR_LOAD;
                    end else begin
                        w_state_nxt = TURN;
                    end
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt         = TURN;
                    w_done_nxt[r_owner] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            TURN: begin
                if (r_write) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = c_RD_LOAD;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt         = IDLE;
                    w_done_nxt[r_owner] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_owner <= 1'b0;
            r_write <= 1'b0;
            r_dout  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_acc_idx;
                r_write <= w_acc_write;
                if (w_acc_write) begin
                    r_dout <= w_acc_idx ? req_wdata1 : req_wdata0;
                end
            end
            if (w_sample) begin
                r_rdata <= port_din;
            end
        end
    end

endmodule : port_bus_arbiter

`default_nettype wire

// File: tb/tb_port_bus_arbiter.sv
//==============================================================================
// Module      : tb_port_bus_arbiter
// Description : Self-checking bench for port_bus_arbiter against a
//               transaction-timing reference model. Honours PORT_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_port_bus_arbiter;
    import port_arb_pkg::*;

    localparam int DW      = 32;
    localparam int WR_HOLD = 2;
    localparam int RD_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_write;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          port_oe;
    logic [DW-1:0] port_dout;
    logic [DW-1:0] port_din;

    int total = 0;
    int bad   = 0;

    // Reference model: a transfer is an accept cycle plus fixed phase offsets.
    bit            m_active;
    bit            m_wr;
    int            m_own;
    int            m_tacc;
    int            m_pref;
    int            n;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_smp;
    logic [1:0]    m_acc;

    port_bus_arbiter #(
        .DW      (DW),
        .WR_HOLD (WR_HOLD),
        .RD_WAIT (RD_WAIT)
    ) u_dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_wdata0    (req_wdata0),
        .req_wdata1    (req_wdata1),
        .done          (done),
        .rdata         (rdata),
        .port_oe       (port_oe),
        .port_dout     (port_dout),
        .port_din      (port_din)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    function automatic int pick();
        if (req_valid == 2'b11) begin
`ifdef PORT_ARB_FIXED_PRIO_EN
            return 0;
`else
            return m_pref;
`endif
        end
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pref   = 0;
        m_rdata  = '0;
        m_acc    = '0;
    endtask

    task automatic model_check();
        int         d;
        int         idx;
        bit         idle;
        logic       e_oe;
        logic [1:0] e_done;
        logic [1:0] e_ready;
        d      = n - m_tacc;
        e_done = '0;
        e_oe   = m_active && m_wr && (d >= 1) && (d <= WR_HOLD);
        if (m_active && m_wr && d == WR_HOLD + 1) e_done[m_own] = 1'b1;
        if (m_active && !m_wr && d == RD_WAIT + 2) begin
            e_done[m_own] = 1'b1;
            m_rdata       = m_smp;
        end
        if (m_active && !m_wr && d == RD_WAIT + 1) m_smp = port_din;
        idle    = !m_active || (d >= (m_wr ? WR_HOLD + 2 : RD_WAIT + 2));
        idx     = pick();
        e_ready = '0;
        if (idle && idx >= 0) e_ready[idx] = 1'b1;

        check_eq("ready", {30'd0, req_ready}, {30'd0, e_ready});
        check_eq("oe",    {31'd0, port_oe},   {31'd0, e_oe});
        check_eq("done",  {30'd0, done},      {30'd0, e_done});
        check_eq("rdata", rdata, m_rdata);
        if (e_oe) check_eq("dout", port_dout, m_wdata);

        m_acc = '0;
        if (idle && idx >= 0 && rst_n) begin
            m_active   = 1'b1;
            m_tacc     = n;
            m_own      = idx;
            m_wr       = req_write[idx];
            m_wdata    = (idx == 1) ? req_wdata1 : req_wdata0;
            m_pref     = 1 - idx;
            m_acc[idx] = 1'b1;
        end
        n++;
    endtask

    // Checks at the falling edge, then returns just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int i, input bit wr);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        if (i == 0) req_wdata0 = $urandom;
        else        req_wdata1 = $urandom;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        check_eq("rst_oe",   {31'd0, port_oe}, 32'd0);
        check_eq("rst_done", {30'd0, done},    32'd0);
        check_eq("rst_dout", port_dout,        32'd0);
        check_eq("rst_rdata", rdata,           32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        port_din   = '0;
        n          = 0;
        m_tacc     = 0;
        m_own      = 0;
        m_wr       = 1'b0;
        m_wdata    = '0;
        m_smp      = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single write of 0xDEADBEEF from requester 0.
        req_valid  = 2'b01;
        req_write  = 2'b01;
        req_wdata0 = 32'hDEADBEEF;
        tick();
        req_valid = '0;
        repeat (6) tick();

        // Single read by requester 1 with a fixed port value.
        port_din  = 32'h12345678;
        req_valid = 2'b10;
        req_write = 2'b00;
        tick();
        req_valid = '0;
        repeat (6) tick();
        check_eq("read_rdata", rdata, 32'h12345678);

        // Contention: both valid continuously with mixed directions.
        for (int k = 0; k < 24; k++) begin
            port_din = $urandom;
            if (k == 0 || m_acc[0]) new_req(0, 1'($urandom_range(0, 1)));
            if (k == 0 || m_acc[1]) new_req(1, 1'($urandom_range(0, 1)));
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Write from req 0 immediately followed by a queued read from req 1.
        req_valid  = 2'b11;
        req_write  = 2'b01;
        req_wdata0 = 32'hA5A5_0F0F;
        for (int k = 0; k < 10; k++) begin
            port_din = $urandom;
            if (m_acc[0]) req_valid[0] = 1'b0;
            if (m_acc[1]) req_valid[1] = 1'b0;
            tick();
        end

        // Reset while requester 0 is driving the port.
        req_valid  = 2'b01;
        req_write  = 2'b01;
        req_wdata0 = 32'h0BAD_CAFE;
        while (!m_acc[0] && n < 200) tick();
        req_valid = '0;
        check_eq("pre_rst_oe", {31'd0, port_oe}, 32'd1);
        do_reset();
        new_req(0, 1'b1);
        new_req(1, 1'b0);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // Requester 1 raises valid during req 0's write, then withdraws it.
        req_valid = 2'b01;
        req_write = 2'b01;
        tick();
        req_valid = 2'b10;
        req_write = 2'b00;
        repeat (2) tick();
        req_valid = '0;
        repeat (6) tick();

        // Randomised traffic, including withdrawals before ready.
        for (int k = 0; k < 3000; k++) begin
            port_din = $urandom;
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else new_req(i, 1'($urandom_range(0, 1)));
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i, 1'($urandom_range(0, 1)));
                end
            end
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_port_bus_arbiter

`default_nettype wire
